// File: rtl/cc_pkg.sv
// Shared types and pattern-record layout for the CC pattern driver.
package cc_pkg;

    // Board and test geometry
    localparam int unsigned N_CELLS  = 36;
    localparam int unsigned N_STRIPE = 4;
    localparam int unsigned N_ACT    = 10;
    localparam int unsigned TIMEOUT  = 500;

    // Field widths
    localparam int unsigned PAT_W   = 223;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned ACT_W   = 2;
    localparam int unsigned SCORE_W = 7;

    // MSB of each field group; entry 0 of every group sits at its MSB
    localparam int unsigned COLOR_MSB       = 222;
    localparam int unsigned STRIPE_ROW_MSB  = 114;
    localparam int unsigned STRIPE_COL_MSB  = 102;
    localparam int unsigned STRIPE_TYPE_MSB = 90;
    localparam int unsigned ACT_ROW_MSB     = 86;
    localparam int unsigned ACT_COL_MSB     = 56;
    localparam int unsigned ACT_CODE_MSB    = 26;
    localparam int unsigned SCORE_MSB       = 6;

    typedef enum logic [2:0] {
        StIdle,
        StBoard,
        StGap,
        StAct,
        StWait,
        StReport
    } state_e;

endpackage

// File: rtl/cc_pattern_unpack.sv
// Combinational field select from the latched pattern word by cell/action index.
module cc_pattern_unpack
    import cc_pkg::*;
(
    input  logic [PAT_W-1:0]   pat_i,
    input  logic [5:0]         cell_idx_i,
    input  logic [3:0]         act_idx_i,
    output logic [COLOR_W-1:0] color_o,
    output logic [POS_W-1:0]   stripe_row_o,
    output logic [POS_W-1:0]   stripe_col_o,
    output logic               stripe_type_o,
    output logic [POS_W-1:0]   act_row_o,
    output logic [POS_W-1:0]   act_col_o,
    output logic [ACT_W-1:0]   act_code_o,
    output logic [SCORE_W-1:0] expected_o
);

    // Cell colour and stripe entry; stripe fields read as 0 beyond the stripe list
    always_comb begin
        color_o       = '0;
        stripe_row_o  = '0;
        stripe_col_o  = '0;
        stripe_type_o = 1'b0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (cell_idx_i == 6'(k)) begin
                color_o = pat_i[COLOR_MSB - COLOR_W * k -: COLOR_W];
            end
        end
        for (int k = 0; k < N_STRIPE; k++) begin
            if (cell_idx_i == 6'(k)) begin
                stripe_row_o  = pat_i[STRIPE_ROW_MSB - POS_W * k -: POS_W];
                stripe_col_o  = pat_i[STRIPE_COL_MSB - POS_W * k -: POS_W];
                stripe_type_o = pat_i[STRIPE_TYPE_MSB - k];
            end
        end
    end

    // Action entry selected by action index
    always_comb begin
        act_row_o  = '0;
        act_col_o  = '0;
        act_code_o = '0;
        for (int j = 0; j < N_ACT; j++) begin
            if (act_idx_i == 4'(j)) begin
                act_row_o  = pat_i[ACT_ROW_MSB - POS_W * j -: POS_W];
                act_col_o  = pat_i[ACT_COL_MSB - POS_W * j -: POS_W];
                act_code_o = pat_i[ACT_CODE_MSB - ACT_W * j -: ACT_W];
            end
        end
    end

    assign expected_o = pat_i[SCORE_MSB -: SCORE_W];

endmodule

// File: rtl/cc_pattern_driver.sv
// Drives one pattern into the CC block (board phase, gap, action phase), then
// waits for the score and reports pass/fail with error bits.
module cc_pattern_driver
    import cc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pat_valid,
    output logic         pat_ready,
    input  logic [222:0] pat_data,
    output logic         in_valid_1,
    output logic         in_valid_2,
    output logic [2:0]   in_color,
    output logic [5:0]   in_starting_pos,
    output logic         in_stripe,
    output logic [1:0]   in_action,
    input  logic         out_valid,
    input  logic [6:0]   out_score,
    output logic         done,
    output logic         pass,
    output logic [2:0]   err_code,
    output logic [9:0]   pass_count
);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [5:0]         cell_idx_q, cell_idx_d;
    logic [3:0]         act_idx_q, act_idx_d;
    logic [8:0]         timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               timeout_q, timeout_d;
    logic               err_hold_q, err_hold_d;
    logic [9:0]         pass_count_q, pass_count_d;

    logic [COLOR_W-1:0] u_color;
    logic [POS_W-1:0]   u_stripe_row, u_stripe_col, u_act_row, u_act_col;
    logic               u_stripe_type;
    logic [ACT_W-1:0]   u_act_code;
    logic [SCORE_W-1:0] u_expected;

    logic last_cell, last_act, timer_expired;
    logic report_err2, mismatch, pass_ok;

    cc_pattern_unpack u_unpack (
        .pat_i         (pat_q),
        .cell_idx_i    (cell_idx_q),
        .act_idx_i     (act_idx_q),
        .color_o       (u_color),
        .stripe_row_o  (u_stripe_row),
        .stripe_col_o  (u_stripe_col),
        .stripe_type_o (u_stripe_type),
        .act_row_o     (u_act_row),
        .act_col_o     (u_act_col),
        .act_code_o    (u_act_code),
        .expected_o    (u_expected)
    );

    assign last_cell     = (cell_idx_q == 6'(N_CELLS - 1));
    assign last_act      = (act_idx_q == 4'(N_ACT - 1));
    assign timer_expired = (timer_q == 9'(TIMEOUT - 1));

    // A second out_valid cycle lands in REPORT, so it is folded in live here
    assign report_err2 = err_hold_q | out_valid;
    assign mismatch    = !timeout_q && (score_q != u_expected);
    assign pass_ok     = !timeout_q && !mismatch && !report_err2;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (pat_valid) state_d = StBoard;
            StBoard:  if (last_cell) state_d = StGap;
            StGap:    state_d = StAct;
            StAct:    if (last_act) state_d = StWait;
            StWait:   if (out_valid || timer_expired) state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q        <= '0;
            cell_idx_q   <= '0;
            act_idx_q    <= '0;
            timer_q      <= '0;
            score_q      <= '0;
            timeout_q    <= 1'b0;
            err_hold_q   <= 1'b0;
            pass_count_q <= '0;
        end else begin
            pat_q        <= pat_d;
            cell_idx_q   <= cell_idx_d;
            act_idx_q    <= act_idx_d;
            timer_q      <= timer_d;
            score_q      <= score_d;
            timeout_q    <= timeout_d;
            err_hold_q   <= err_hold_d;
            pass_count_q <= pass_count_d;
        end
    end

    // Datapath next-state: latch, counters, score capture and error flags
    always_comb begin
        pat_d        = pat_q;
        cell_idx_d   = cell_idx_q;
        act_idx_d    = act_idx_q;
        timer_d      = timer_q;
        score_d      = score_q;
        timeout_d    = timeout_q;
        err_hold_d   = err_hold_q;
        pass_count_d = pass_count_q;
        case (state_q)
            StIdle: begin
                if (pat_valid) begin
                    pat_d      = pat_data;
                    cell_idx_d = '0;
                    act_idx_d  = '0;
                    timer_d    = '0;
                    score_d    = '0;
                    timeout_d  = 1'b0;
                    err_hold_d = 1'b0;
                end
            end
            StBoard: begin
                if (!last_cell) cell_idx_d = cell_idx_q + 6'd1;
                if (out_valid) err_hold_d = 1'b1;
            end
            StGap: begin
                if (out_valid) err_hold_d = 1'b1;
            end
            StAct: begin
                if (!last_act) act_idx_d = act_idx_q + 4'd1;
                if (last_act) timer_d = '0;
                if (out_valid) err_hold_d = 1'b1;
            end
            StWait: begin
                if (out_valid) begin
                    score_d = out_score;
                end else begin
                    timer_d = timer_q + 9'd1;
                    if (timer_expired) timeout_d = 1'b1;
                end
            end
            StReport: begin
                if (pass_ok && (pass_count_q != 10'h3ff)) pass_count_d = pass_count_q + 10'd1;
            end
            default: ;
        endcase
    end

    // Outputs; data buses are zero whenever their valid is low
    always_comb begin
        pat_ready       = 1'b0;
        in_valid_1      = 1'b0;
        in_valid_2      = 1'b0;
        in_color        = '0;
        in_starting_pos = '0;
        in_stripe       = 1'b0;
        in_action       = '0;
        done            = 1'b0;
        pass            = 1'b0;
        err_code        = '0;
        case (state_q)
            StIdle: pat_ready = 1'b1;
            StBoard: begin
                in_valid_1      = 1'b1;
                in_color        = u_color;
                in_starting_pos = {u_stripe_row, u_stripe_col};
                in_stripe       = u_stripe_type;
            end
            StAct: begin
                in_valid_2      = 1'b1;
                in_starting_pos = {u_act_row, u_act_col};
                in_action       = u_act_code;
            end
            StReport: begin
                done     = 1'b1;
                pass     = pass_ok;
                err_code = {report_err2, timeout_q, mismatch};
            end
            default: ;
        endcase
    end

    assign pass_count = pass_count_q;

endmodule

// File: doc/cc_pattern_driver.md
CC_PATTERN_DRIVER -- requirements
Module: cc_pattern_driver

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 pat_valid  input  1  pattern word offered.
REQ-004 pat_ready  output  1  driver idle, accepts pattern.
REQ-005 pat_data  input  223  packed pattern record: [222:115] 36 colours, 3b each, cell 0 at MSB; [114:103] 4 stripe rows; [102:91] 4 stripe cols; [90:87] 4 stripe types; [86:57] 10 action rows; [56:27] 10 action cols; [26:7] 10 actions, 2b each; [6:0] expected score.
REQ-006 in_valid_1, in_valid_2  output  1 each  board-phase and action-phase valids to CC.
REQ-007 in_color  output  3  cell colour.
REQ-008 in_starting_pos  output  6  {row[2:0], col[2:0]}.
REQ-009 in_stripe  output  1  stripe type.
REQ-010 in_action  output  2  action code.
REQ-011 out_valid  input  1  CC result valid.
REQ-012 out_score  input  7  CC score.
REQ-013 done  output  1  one-cycle pulse, pattern finished.
REQ-014 pass  output  1  valid with done; score matched.
REQ-015 err_code  output  3  valid with done: bit0 mismatch, bit1 timeout, bit2 out_valid held >1 cycle.
REQ-016 pass_count  output  10  patterns passed since reset, saturating at 1023.

Function
REQ-017 States: IDLE, BOARD, GAP, ACT, WAIT, REPORT.
REQ-018 IDLE: pat_ready=1; pat_valid=1 latches pat_data and enters BOARD next cycle.
REQ-019 BOARD: exactly 36 cycles, in_valid_1=1, in_color = colour k for k=0..35.
REQ-020 BOARD k=0..3: in_starting_pos and in_stripe from stripe entry k; k>=4: both 0.
REQ-021 GAP: exactly 1 cycle, all valids 0.
REQ-022 ACT: exactly 10 cycles, in_valid_2=1, in_starting_pos and in_action from action entry j, j=0..9.
REQ-023 Whenever the matching valid is 0, in_color, in_starting_pos, in_stripe and in_action are driven 0.
REQ-024 WAIT: timer cleared on entry, +1 per cycle; the first out_valid=1 captures out_score and enters REPORT; timer reaching 500 sets timeout and enters REPORT.
REQ-025 out_valid high on the cycle after capture sets err bit2; sampled only in REPORT.
REQ-026 out_valid during BOARD, GAP or ACT sets err bit2 and is otherwise ignored.
REQ-027 REPORT: 1 cycle; done=1; pass=1 iff captured score == expected, no timeout and err bit2=0; pass_count increments on pass; return to IDLE.
REQ-028 pat_valid outside IDLE is ignored; no queuing.
REQ-029 Counters: 6-bit cell index, 4-bit action index, 9-bit timer; no wrap inside any state.

Reset
REQ-030 rst_n=0 at a clock edge, including mid-pattern: state IDLE; all outputs 0 except pat_ready=1; pass_count 0; latched pattern and error flags cleared.

Structure
REQ-031 Shared package cc_pkg: state enum, pattern field offsets/widths, N_CELLS=36, N_STRIPE=4, N_ACT=10, TIMEOUT=500.
REQ-032 One sub-module, cc_pattern_unpack: combinational field select from the latched word by cell/action index.

Verification
REQ-033 Colours 0..5 cycling, stripes at (0,0),(1,1),(2,2),(3,3) type 1, expected 7'd12, model returns 12 -> in_valid_1 high 36 cycles, 1 gap, in_valid_2 high 10 cycles, done with pass=1, pass_count=1.
REQ-034 Same pattern, model returns 11 -> pass=0, err_code=3'b001, pass_count unchanged.
REQ-035 Model never asserts out_valid -> done exactly 500 cycles after WAIT entry, err_code=3'b010.
REQ-036 Model holds out_valid 2 cycles, correct score -> pass=0, err_code=3'b100.
REQ-037 rst_n low at BOARD cycle 20 -> next cycle in_valid_1=0, pat_ready=1; new pattern then runs full 36+1+10 sequence.
REQ-038 Five back-to-back correct patterns -> pass_count=5; pat_ready low from acceptance through REPORT.
